// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - issue/stall/writeback wrapper for the multi-cycle multiplier and divider
// Optional feature macro: MD_TRIVIAL_BYPASS_EN (multiply by 0/1 completes without launching the unit)
module multdiv_issue_ctrl #(
    parameter logic [4:0]  STATUS_REG = 5'd30,
    parameter logic [31:0] EXC_MULT   = 32'd4,
    parameter logic [31:0] EXC_DIV    = 32'd5,
    parameter int          TIMEOUT    = 48
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        busy,
    output logic        md_start,
    output logic        md_sel_div,
    output logic        md_interrupt,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    input  logic [31:0] md_result,
    input  logic        md_finish,
    input  logic        md_overflow,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exc,
    input  logic        wb_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [4:0]  rd_q;
    logic        bypass;
    logic [31:0] bypass_data;
    logic        timed_out;
    logic [31:0] exc_code;

`ifdef MD_TRIVIAL_BYPASS_EN
    always_comb begin
        bypass      = 1'b0;
        bypass_data = 32'd0;
        if (!in_op) begin
            if (in_a == 32'd0 || in_b == 32'd0) begin
                bypass      = 1'b1;
                bypass_data = 32'd0;
            end else if (in_a == 32'd1) begin
                bypass      = 1'b1;
                bypass_data = in_b;
            end else if (in_b == 32'd1) begin
                bypass      = 1'b1;
                bypass_data = in_a;
            end
        end
    end
`else
    assign bypass      = 1'b0;
    assign bypass_data = 32'd0;
`endif

    assign busy      = (state != S_IDLE);
    assign timed_out = (state == S_WAIT) && !md_finish && (cnt == CNT_LAST);
    assign exc_code  = md_sel_div ? EXC_DIV : EXC_MULT;

    // A flush kills the op before the unit can see a start alongside the abort.
    assign md_start     = (state == S_START) && !flush;
    assign md_interrupt = (flush && (state == S_START || state == S_WAIT)) ||
                          (timed_out && !flush);
    assign wb_valid     = (state == S_DONE) && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= 6'd0;
            rd_q       <= 5'd0;
            md_sel_div <= 1'b0;
            md_opA     <= 32'd0;
            md_opB     <= 32'd0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            wb_exc     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        md_opA     <= in_a;
                        md_opB     <= in_b;
                        md_sel_div <= in_op;
                        rd_q       <= in_rd;
                        if (bypass) begin
                            wb_rd   <= in_rd;
                            wb_data <= bypass_data;
                            wb_exc  <= 1'b0;
                            state   <= S_DONE;
                        end else begin
                            state <= S_START;
                        end
                    end
                end
                S_START: begin
                    cnt   <= 6'd0;
                    state <= flush ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (md_finish && !md_overflow) begin
                        wb_rd   <= rd_q;
                        wb_data <= md_result;
                        wb_exc  <= 1'b0;
                        state   <= S_DONE;
                    end else if (md_finish || timed_out) begin
                        wb_rd   <= STATUS_REG;
                        wb_data <= exc_code;
                        wb_exc  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: begin
                    if (flush || wb_ready) state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
